// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker: checker state encoding and the
// Fibonacci LFSR tap function it has in common with the generator.
package prbs_checker_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // XOR of the generator taps for an n-bit register; v[0] holds the newest bit.
  function automatic logic lfsr_fb(input int n, input logic [7:0] v);
    logic fb;
    case (n)
      3:       fb = v[2] ^ v[1];
      4:       fb = v[3] ^ v[2];
      5:       fb = v[4] ^ v[2];
      6:       fb = v[5] ^ v[4];
      7:       fb = v[6] ^ v[5];
      8:       fb = v[7] ^ v[5] ^ v[4] ^ v[3];
      default: fb = 1'b0;
    endcase
    return fb;
  endfunction

endpackage

// File: rtl/prbs_predict.sv
// Combinational next-bit predictor: given the last N received bits, produce the
// bit the generator must emit next.
module prbs_predict
  import prbs_checker_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] sr,
  output logic         pred
);

  logic [7:0] sr_ext;

  assign sr_ext = 8'(sr);
  assign pred   = lfsr_fb(N, sr_ext);

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to an N-bit Fibonacci LFSR stream,
// declares lock, then counts bit errors until too many arrive close together.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int N           = 4,
  parameter int LOCK_CNT    = 8,
  parameter int LOSS_THRESH = 4,
  parameter int ERRW        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            din_valid,
  input  logic            din,
  input  logic            clr_cnt,
  output logic            locked,
  output logic [1:0]      state,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count
);

  localparam int FW = $clog2(N + 1);
  localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int RW = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH + 1);

  localparam logic [FW-1:0]   FILL_FULL  = FW'(N);
  localparam logic [FW-1:0]   FILL_LAST  = FW'(N - 1);
  localparam logic [MW-1:0]   MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [RW-1:0]   RUN_LAST   = RW'(LOSS_THRESH - 1);
  localparam logic [N-1:0]    CLEAN_LAST = N'((1 << N) - 2);
  localparam logic [ERRW-1:0] CNT_MAX    = {ERRW{1'b1}};

  generate
    if (N < 3 || N > 8) begin : g_bad_n
      $error("prbs_checker: N must be in 3..8");
    end
    if (LOCK_CNT < 1) begin : g_bad_lock
      $error("prbs_checker: LOCK_CNT must be at least 1");
    end
    if (LOSS_THRESH < 1) begin : g_bad_loss
      $error("prbs_checker: LOSS_THRESH must be at least 1");
    end
  endgenerate

  state_t        state_reg;
  logic [N-1:0]  sr_reg;
  logic [FW-1:0] fill_reg;
  logic [MW-1:0] match_reg;
  logic [RW-1:0] err_run_reg;
  logic [N-1:0]  clean_reg;

  logic          pred;
  logic          correct;
  logic [N-1:0]  sr_din_next;
  logic [N-1:0]  sr_pred_next;
  logic          fill_done;

  prbs_predict #(.N(N)) u_predict (
    .sr   (sr_reg),
    .pred (pred)
  );

  always_comb begin
    correct      = (din == pred);
    sr_din_next  = {sr_reg[N-2:0], din};
    sr_pred_next = {sr_reg[N-2:0], pred};
    // The bit being shifted in now completes the N-bit window.
    fill_done    = (fill_reg >= FILL_LAST);
  end

  assign state = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_SEARCH;
      sr_reg      <= '0;
      fill_reg    <= '0;
      match_reg   <= '0;
      err_run_reg <= '0;
      clean_reg   <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (din_valid) begin
        case (state_reg)
          ST_SEARCH: begin
            sr_reg <= sr_din_next;
            if (fill_reg != FILL_FULL) begin
              fill_reg <= fill_reg + FW'(1);
            end
            if (fill_done && (sr_din_next != '0)) begin
              state_reg <= ST_SYNC;
              match_reg <= '0;
            end
          end

          ST_SYNC: begin
            sr_reg <= sr_din_next;
            if (sr_din_next == '0) begin
              state_reg <= ST_SEARCH;
              fill_reg  <= '0;
              match_reg <= '0;
            end else if (correct) begin
              if (match_reg == MATCH_LAST) begin
                state_reg   <= ST_LOCKED;
                locked      <= 1'b1;
                match_reg   <= '0;
                err_run_reg <= '0;
                clean_reg   <= '0;
              end else begin
                match_reg <= match_reg + MW'(1);
              end
            end else begin
              match_reg <= '0;
            end
          end

          ST_LOCKED: begin
            // Free-run on the prediction so a single flipped bit is one error.
            sr_reg <= sr_pred_next;
            if (!correct) begin
              err_pulse <= 1'b1;
              clean_reg <= '0;
              if (err_count != CNT_MAX) begin
                err_count <= err_count + ERRW'(1);
              end
              if (err_run_reg == RUN_LAST) begin
                state_reg   <= ST_SEARCH;
                locked      <= 1'b0;
                fill_reg    <= '0;
                match_reg   <= '0;
                err_run_reg <= '0;
              end else begin
                err_run_reg <= err_run_reg + RW'(1);
              end
            end else if (clean_reg == CLEAN_LAST) begin
              clean_reg   <= '0;
              err_run_reg <= '0;
            end else begin
              clean_reg <= clean_reg + N'(1);
            end
          end

          default: begin
            state_reg <= ST_SEARCH;
            fill_reg  <= '0;
            match_reg <= '0;
            locked    <= 1'b0;
          end
        endcase
      end
      // Placed last so a clear beats a same-cycle increment.
      if (clr_cnt) begin
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: seven instances (N=3..8 plus a narrow-counter
// N=4) run the same scenarios against a per-instance reference model.
module tb_prbs_checker;

  localparam int NI = 7;
  localparam int NS [NI] = '{3, 4, 5, 6, 7, 8, 4};

  logic clk = 1'b0;
  logic rst_n;
  logic din_valid;
  logic clr_cnt;
  logic        din_a    [NI];
  logic        locked_a [NI];
  logic [1:0]  state_a  [NI];
  logic        pulse_a  [NI];
  logic [15:0] cnt_a    [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int EW = (gi == 6) ? 4 : 16;
      logic [EW-1:0] cnt_w;
      prbs_checker #(
        .N(NS[gi]), .LOCK_CNT(8), .LOSS_THRESH(4), .ERRW(EW)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_valid (din_valid),
        .din       (din_a[gi]),
        .clr_cnt   (clr_cnt),
        .locked    (locked_a[gi]),
        .state     (state_a[gi]),
        .err_pulse (pulse_a[gi]),
        .err_count (cnt_w)
      );
      assign cnt_a[gi] = 16'(cnt_w);
    end
  endgenerate

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: mode 0 hunting, 1 confirming, 2 locked.
  int         m_mode  [NI];
  logic [7:0] m_hist  [NI];
  int         m_fill  [NI];
  int         m_match [NI];
  int         m_run   [NI];
  int         m_clean [NI];
  int         m_cnt   [NI];
  bit         m_lock  [NI];
  bit         m_pulse [NI];
  logic [7:0] gen     [NI];

  function automatic logic taps_xor(input int n, input logic [7:0] h);
    int taps[$];
    logic r;
    r = 1'b0;
    case (n)
      3: taps = '{2, 1};
      4: taps = '{3, 2};
      5: taps = '{4, 2};
      6: taps = '{5, 4};
      7: taps = '{6, 5};
      default: taps = '{7, 5, 4, 3};
    endcase
    foreach (taps[i]) r ^= h[taps[i]];
    return r;
  endfunction

  task automatic check(input string name, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d(N=%0d) t=%0t: got %0d, want %0d", name, k, NS[k], $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_mode[k] = 0; m_hist[k] = '0; m_fill[k] = 0; m_match[k] = 0;
      m_run[k] = 0; m_clean[k] = 0; m_cnt[k] = 0; m_lock[k] = 0; m_pulse[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit v, input logic d, input bit clr);
    int n, maxc;
    logic [7:0] mask;
    logic p;
    n    = NS[k];
    mask = 8'((1 << n) - 1);
    maxc = (k == 6) ? 15 : 65535;
    m_pulse[k] = 0;
    if (v) begin
      p = taps_xor(n, m_hist[k]);
      case (m_mode[k])
        0: begin
          m_hist[k] = ((m_hist[k] << 1) | 8'(d)) & mask;
          if (m_fill[k] < n) m_fill[k]++;
          if (m_fill[k] == n && m_hist[k] != 0) begin m_mode[k] = 1; m_match[k] = 0; end
        end
        1: begin
          m_hist[k] = ((m_hist[k] << 1) | 8'(d)) & mask;
          if (m_hist[k] == 0) begin
            m_mode[k] = 0; m_fill[k] = 0; m_match[k] = 0;
          end else if (d == p) begin
            m_match[k]++;
            if (m_match[k] == 8) begin
              m_mode[k] = 2; m_lock[k] = 1; m_run[k] = 0; m_clean[k] = 0;
            end
          end else begin
            m_match[k] = 0;
          end
        end
        default: begin
          m_hist[k] = ((m_hist[k] << 1) | 8'(p)) & mask;
          if (d != p) begin
            m_pulse[k] = 1;
            if (m_cnt[k] < maxc) m_cnt[k]++;
            m_clean[k] = 0;
            m_run[k]++;
            if (m_run[k] == 4) begin
              m_mode[k] = 0; m_lock[k] = 0; m_fill[k] = 0; m_match[k] = 0; m_run[k] = 0;
            end
          end else begin
            m_clean[k]++;
            if (m_clean[k] == (1 << n) - 1) begin m_clean[k] = 0; m_run[k] = 0; end
          end
        end
      endcase
    end
    if (clr) m_cnt[k] = 0;
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check("locked", k, int'(locked_a[k]), int'(m_lock[k]));
        check("state", k, int'(state_a[k]), m_mode[k]);
        check("err_pulse", k, int'(pulse_a[k]), int'(m_pulse[k]));
        check("err_count", k, int'(cnt_a[k]), m_cnt[k]);
      end
    end
  end

  // One cycle: drive inputs, clock, update model, return at the next falling edge.
  task automatic step(input bit v, input bit clr, input bit flip, input bit zero = 1'b0);
    logic g [NI];
    din_valid = v;
    clr_cnt   = clr;
    for (int k = 0; k < NI; k++) begin
      g[k] = taps_xor(NS[k], gen[k]);
      if (zero)   din_a[k] = 1'b0;
      else if (v) din_a[k] = g[k] ^ flip;
      else        din_a[k] = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      model_step(k, v, din_a[k], clr);
      if (v && !zero) gen[k] = ((gen[k] << 1) | 8'(g[k])) & 8'((1 << NS[k]) - 1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts N+7 / N+8 valid bits of a clean stream and pins the lock point.
  task automatic run_to_lock(input bit toggle);
    int vc;
    vc = 0;
    for (int i = 0; i < (toggle ? 40 : 16); i++) begin
      bit v;
      v = toggle ? (i % 2 == 0) : 1'b1;
      step(v, 1'b0, 1'b0);
      if (v) begin
        vc++;
        for (int k = 0; k < NI; k++) begin
          if (vc == NS[k])     check("sync_at_N", k, int'(state_a[k]), 1);
          if (vc == NS[k] + 7) check("unlocked_at_N+7", k, int'(locked_a[k]), 0);
          if (vc == NS[k] + 8) check("locked_at_N+8", k, int'(locked_a[k]), 1);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      gen[k] = 8'd1;
      din_a[k] = 1'b0;
    end
    rst_n = 1'b0;
    din_valid = 1'b0;
    clr_cnt = 1'b0;
    model_reset();
    @(negedge clk);
    chk_en = 1'b1;
    do_reset();
    for (int k = 0; k < NI; k++) check("reset_count", k, int'(cnt_a[k]), 0);

    // First four N=4 bits from seed 0001 are 0,0,1,1.
    begin
      logic [3:0] first4;
      first4 = 4'b0011;
      for (int b = 0; b < 4; b++) begin
        logic gb;
        gb = taps_xor(4, gen[1]);
        check("gen_bit_N4", 1, int'(gb), int'(first4[3-b]));
        gen[1] = ((gen[1] << 1) | 8'(gb)) & 8'hF;
      end
      gen[1] = 8'd1;
    end

    // Clean stream: lock point, then a long error-free run.
    run_to_lock(1'b0);
    repeat (1000) step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NI; k++) check("clean_run_count", k, int'(cnt_a[k]), 0);

    // A single flipped bit.
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < NI; k++) begin
      check("single_err_pulse", k, int'(pulse_a[k]), 1);
      check("single_err_count", k, int'(cnt_a[k]), 1);
      check("single_err_locked", k, int'(locked_a[k]), 1);
    end
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NI; k++) check("pulse_one_cycle", k, int'(pulse_a[k]), 0);

    // Burst of four errors drops lock; relock follows.
    repeat (300) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0, 1'b1);
      if (j < 3) repeat (2) step(1'b1, 1'b0, 1'b0);
    end
    for (int k = 0; k < NI; k++) begin
      check("burst_unlocked", k, int'(locked_a[k]), 0);
      check("burst_count", k, int'(cnt_a[k]), 4);
    end
    run_to_lock(1'b0);

    // Saturation of the 4-bit counter instance.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
      end
      repeat (20) step(1'b1, 1'b0, 1'b0);
      if (r >= 2) check("saturated_count", 6, int'(cnt_a[6]), 15);
    end
    check("wide_count", 1, int'(cnt_a[1]), 20);

    // Clear with a simultaneous error.
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < NI; k++) begin
      check("clr_wins_count", k, int'(cnt_a[k]), 0);
      check("clr_pulse", k, int'(pulse_a[k]), 1);
    end
    step(1'b1, 1'b0, 1'b0);

    // Asynchronous reset while locked.
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("async_rst_locked", k, int'(locked_a[k]), 0);
      check("async_rst_state", k, int'(state_a[k]), 0);
      check("async_rst_pulse", k, int'(pulse_a[k]), 0);
      check("async_rst_count", k, int'(cnt_a[k]), 0);
    end
    model_reset();
    do_reset();

    // All-zero input never leaves search.
    repeat (50) step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < NI; k++) begin
      check("zeros_state", k, int'(state_a[k]), 0);
      check("zeros_locked", k, int'(locked_a[k]), 0);
    end

    // Gapped valid: same lock point counted in valid bits.
    do_reset();
    run_to_lock(1'b1);
    repeat (30) step(1'b1, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
